// File: rtl/iter_muldiv_unit_if.sv
// Handshake and operand/result bundle between the control unit and the
// iterative multiply/divide unit.
interface iter_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, abort,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle MIPS-style multiply/divide: one bit per cycle on operand
// magnitudes, sign correction at the end, HI/LO held between operations.
//
//  state | meaning
//  IDLE  | waiting for start
//  PREP  | take magnitudes, record result signs, catch divide-by-zero
//  RUN   | WIDTH shift-add / restoring shift-subtract steps
//  FIXUP | apply signs and load hi/lo
//  DONE  | one-cycle done pulse; a new start is accepted here
module iter_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    iter_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_RUN   = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, dbz_q, dbz_d;

    logic               is_div, is_signed;
    logic [WIDTH-1:0]   a_abs, b_abs, mul_addend, rem_hi, quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_div     = op_q[1];
    assign is_signed  = ~op_q[0];
    assign a_abs      = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_abs      = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Upper accumulator half is the partial product (multiply) or partial remainder (divide).
    assign rem_hi     = acc_q[2*WIDTH-1:WIDTH];
    assign mul_addend = a_q[0] ? b_q : '0;
    assign mul_sum    = {1'b0, rem_hi} + {1'b0, mul_addend};
    assign rem_sh     = {rem_hi, a_q[WIDTH-1]};
    assign rem_diff   = rem_sh - {1'b0, b_q};
    assign prod_fix   = neg_q ? -acc_q : acc_q;
    assign quo_fix    = neg_q ? -a_q : a_q;
    assign rem_fix    = rneg_q ? -rem_hi : rem_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_PREP;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                if (is_div && (b_q == '0)) begin
                    state_d = S_DONE;
                    hi_d    = a_q;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = S_RUN;
                    cnt_d   = CW'(WIDTH);
                    a_d     = a_abs;
                    b_d     = b_abs;
                    acc_d   = '0;
                    neg_d   = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rneg_d  = is_signed && a_q[WIDTH-1];
                end
            end
            S_RUN: begin
                if (is_div) begin
                    // Quotient bits shift into a_q as dividend bits shift out.
                    if (!rem_diff[WIDTH]) begin
                        acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-1:0]};
                        a_d   = {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-1:0]};
                        a_d   = {a_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    a_d   = a_q >> 1;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_d = S_DONE;
                dbz_d   = 1'b0;
                if (is_div) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort drops the operation and leaves the visible results untouched.
        if (bus.abort) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            S_PREP, S_RUN, S_FIXUP: bus.busy = 1'b1;
            S_DONE:                 bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit at WIDTH=32: expected hi/lo/div_by_zero
// are queued when an operation starts and compared when done pulses.
module tb_iter_muldiv_unit;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    iter_muldiv_unit_if #(.WIDTH(W)) bus ();

    iter_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t               e;
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0]        up;
        sa = {{32{a[W-1]}}, a};
        sb = {{32{b[W-1]}}, b};
        e  = '0;
        case (op)
            2'b00: begin sp = sa * sb; e.hi = sp[63:32]; e.lo = sp[31:0]; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            default: begin
                if (b == '0) begin
                    e.hi = a; e.lo = '1; e.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    sq = sa / sb; sr = sa % sb;
                    e.hi = sr[31:0]; e.lo = sq[31:0];
                end else begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Drive one start pulse and wait (bounded) for done; lat=-1 on timeout.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt);
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        lat = -1; bcnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) bcnt++;
            if (bus.done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.div_by_zero});
        end
        checks++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            errors++; $display("FAIL reset_hilo got %h want 0", {bus.hi, bus.lo});
        end
        reset = 1'b0;
    endtask

    task automatic test_vectors();
        logic [1:0]   v_op[6]  = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [W-1:0] v_a[6]   = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h64, 32'h5};
        logic [W-1:0] v_b[6]   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'h0, 32'h0};
        logic [W-1:0] v_hi[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h64, 32'h5};
        logic [W-1:0] v_lo[6]  = '{32'hFFFFFFEB, 32'h1, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic         v_dbz[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int           v_lat[6] = '{35, 35, 35, 35, 2, 2};
        int   lat, bcnt;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{hi: v_hi[i], lo: v_lo[i], dbz: v_dbz[i]});
            run_op(v_op[i], v_a[i], v_b[i], lat, bcnt);
            checks++;
            if (lat !== v_lat[i]) begin
                errors++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, v_lat[i]);
            end
            checks++;
            if (bcnt !== v_lat[i] - 1) begin
                errors++; $display("FAIL vec%0d_busy_cycles got %0d want %0d", i, bcnt, v_lat[i] - 1);
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL vec%0d_scoreboard empty on done", i);
            end else begin
                e = sb_q.pop_front();
                if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
                    errors++;
                    $display("FAIL vec%0d_result got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                             i, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.div_by_zero !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL dbz_hold got dbz=%b done=%b want dbz=1 done=0", bus.div_by_zero, bus.done);
        end
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a, b;
        int   lat, bcnt, want_lat;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 3));
            if (i == 0) begin op = 2'b01; a = 32'h6; b = 32'h7; end
            want_lat = (op[1] && b == '0) ? 2 : 35;
            sb_q.push_back(model(op, a, b));
            run_op(op, a, b, lat, bcnt);
            checks++;
            if (lat !== want_lat) begin
                errors++; $display("FAIL rand%0d_latency op=%0d got %0d want %0d", i, op, lat, want_lat);
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL rand%0d_scoreboard empty on done", i);
            end else begin
                e = sb_q.pop_front();
                if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
                    errors++;
                    $display("FAIL rand%0d_result op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                             i, op, a, b, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
                end
            end
        end
        // Leave a known result behind for the abort test.
        sb_q.push_back('{hi: 32'h0, lo: 32'h2A, dbz: 1'b0});
        run_op(2'b01, 32'h6, 32'h7, lat, bcnt);
        checks++;
        e = sb_q.pop_front();
        if (lat !== 35 || {bus.hi, bus.lo} !== {e.hi, e.lo}) begin
            errors++; $display("FAIL pre_abort_op got lat=%0d lo=%h want lat=35 lo=%h", lat, bus.lo, e.lo);
        end
    endtask

    task automatic test_abort();
        bit seen_done = 0;
        @(negedge clk);
        bus.op = 2'b01; bus.a = 32'h3; bus.b = 32'h5; bus.start = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) seen_done = 1;
            if (k == 9)  begin bus.op = 2'b11; bus.a = 32'h9; bus.b = 32'h2; bus.start = 1'b1; end
            if (k == 19) bus.abort = 1'b1;
            if (k == 20) begin
                bus.abort = 1'b0;
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++; $display("FAIL abort_busy got %b want 0", bus.busy);
                end
            end
        end
        checks++;
        if (seen_done) begin
            errors++; $display("FAIL abort_no_done got done pulse want none");
        end
        checks++;
        if ({bus.hi, bus.lo, bus.div_by_zero} !== {32'h0, 32'h2A, 1'b0}) begin
            errors++; $display("FAIL abort_hold got hi=%h lo=%h dbz=%b want hi=0 lo=2a dbz=0",
                               bus.hi, bus.lo, bus.div_by_zero);
        end
        @(negedge clk);
        bus.op = 2'b01; bus.a = 32'h2; bus.b = 32'h2; bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL abort_beats_start got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int   first_k = -1, second_k = -1;
        exp_t e;
        sb_q.push_back('{hi: 32'h0, lo: 32'hF, dbz: 1'b0});
        @(negedge clk);
        bus.op = 2'b01; bus.a = 32'h3; bus.b = 32'h5; bus.start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 34) begin
                bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
                sb_q.push_back('{hi: 32'd2, lo: 32'd14, dbz: 1'b0});
            end
            if (k == 36) begin
                bus.start = 1'b0;
                checks++;
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    errors++; $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
                end
            end
            if (bus.done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL b2b_scoreboard empty on done at cycle %0d", k);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
                        errors++; $display("FAIL b2b_result got hi=%h lo=%h want hi=%h lo=%h",
                                           bus.hi, bus.lo, e.hi, e.lo);
                    end
                end
                if (first_k < 0) first_k = k;
                else begin second_k = k; break; end
            end
        end
        checks++;
        if (first_k !== 35 || second_k !== 70) begin
            errors++; $display("FAIL b2b_timing got first=%0d second=%0d want 35 70", first_k, second_k);
        end
    endtask

    task automatic test_reset_mid_op();
        int   lat, bcnt;
        exp_t e;
        @(negedge clk);
        bus.op = 2'b11; bus.a = 32'h9; bus.b = 32'h2; bus.start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== 67'h0) begin
            errors++; $display("FAIL reset_mid_op got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
                               bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset = 1'b0;
        sb_q.push_back(model(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF));
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        checks++;
        e = sb_q.pop_front();
        if (lat !== 35 || {bus.hi, bus.lo} !== {e.hi, e.lo}) begin
            errors++; $display("FAIL post_reset_op got lat=%0d hi=%h lo=%h want lat=35 hi=%h lo=%h",
                               lat, bus.hi, bus.lo, e.hi, e.lo);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_mid_op();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
